// File: rtl/conv_col_gen.sv
// conv_col_gen: raster-to-column generator with two line buffers and an end-of-frame flush row
// Ports:
//   clk, arst        clock and asynchronous active-high reset
//   in_vld_i/in_rdy_o/in_dat_i/in_sof_i   raster pixel input handshake, sof resyncs to (0,0)
//   col_push_o       one column per accepted pixel or flush step, no backpressure
//   col_vld_o        per-row real-data flags, 0 marks padding rows
//   col_dat_o        column pixels, [N-1] newest row, [0] oldest row
//   col_pos_o        {flush, last_row, first_row, eol, sol}
module conv_col_gen #(
    parameter int KERNEL_DIAMETER_N = 3,
    parameter int PIXEL_W           = 8,
    parameter int IMAGE_W           = 8,
    parameter int IMAGE_H           = 4,
    parameter int KERNEL_POS_W      = 5
) (
    input  logic                                            clk,
    input  logic                                            arst,
    input  logic                                            in_vld_i,
    output logic                                            in_rdy_o,
    input  logic [PIXEL_W-1:0]                              in_dat_i,
    input  logic                                            in_sof_i,
    output logic                                            col_push_o,
    output logic [KERNEL_DIAMETER_N-1:0]                    col_vld_o,
    output logic [KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0]       col_dat_o,
    output logic [KERNEL_POS_W-1:0]                         col_pos_o
);
    localparam int XW = $clog2(IMAGE_W);
    localparam int YW = $clog2(IMAGE_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_H - 1);

    typedef enum logic {STREAM, FLUSH} state_t;

    state_t             r_state;
    logic [XW-1:0]      r_x;
    logic [XW-1:0]      r_fx;
    logic [YW-1:0]      r_y;
    logic [PIXEL_W-1:0] r_lb0 [IMAGE_W];
    logic [PIXEL_W-1:0] r_lb1 [IMAGE_W];

    logic               w_acc;
    logic [XW-1:0]      w_cx;
    logic [YW-1:0]      w_cy;
    logic               w_last_x;
    logic               w_last_y;
    logic               w_v1;
    logic               w_v0;
    logic [PIXEL_W-1:0] w_rd0;
    logic [PIXEL_W-1:0] w_rd1;
    logic [PIXEL_W-1:0] w_d1;
    logic [PIXEL_W-1:0] w_d0;

    assign in_rdy_o = (r_state == STREAM);
    assign w_acc    = in_vld_i & in_rdy_o;
    // sof forces the effective position to (0,0) whatever the counters say
    assign w_cx     = in_sof_i ? '0 : r_x;
    assign w_cy     = in_sof_i ? '0 : r_y;
    assign w_last_x = (w_cx == X_LAST);
    assign w_last_y = (w_cy == Y_LAST);
    // validity comes from the row index, so stale buffer data is always masked
    assign w_v1     = (w_cy != '0);
    assign w_v0     = (w_cy > YW'(1));
    assign w_rd0    = r_lb0[w_cx];
    assign w_rd1    = r_lb1[w_cx];
    assign w_d1     = w_v1 ? w_rd1 : '0;
    assign w_d0     = w_v0 ? w_rd0 : '0;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= STREAM;
            r_x        <= '0;
            r_y        <= '0;
            r_fx       <= '0;
            col_push_o <= 1'b0;
            col_vld_o  <= '0;
            col_dat_o  <= '0;
            col_pos_o  <= '0;
        end else begin
            col_push_o <= 1'b0;
            col_vld_o  <= '0;
            col_dat_o  <= '0;
            col_pos_o  <= '0;
            if (w_acc) begin
                col_push_o <= 1'b1;
                col_vld_o  <= {1'b1, w_v1, w_v0};
                col_dat_o  <= {in_dat_i, w_d1, w_d0};
                col_pos_o  <= {1'b0, w_last_y, w_cy == '0, w_last_x, w_cx == '0};
                r_x        <= w_last_x ? '0 : w_cx + XW'(1);
                r_y        <= w_last_x ? (w_last_y ? '0 : w_cy + YW'(1)) : w_cy;
                if (w_last_x && w_last_y) begin
                    r_state <= FLUSH;
                    r_fx    <= '0;
                end
            end else if (r_state == FLUSH) begin
                col_push_o <= 1'b1;
                col_vld_o  <= 3'b011;
                col_dat_o  <= {{PIXEL_W{1'b0}}, r_lb1[r_fx], r_lb0[r_fx]};
                col_pos_o  <= {2'b11, 1'b0, r_fx == X_LAST, r_fx == '0};
                r_fx       <= (r_fx == X_LAST) ? '0 : r_fx + XW'(1);
                if (r_fx == X_LAST) r_state <= STREAM;
            end
        end
    end

    // each accepted pixel shifts its column up one row in the buffers
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb0[w_cx] <= w_rd1;
            r_lb1[w_cx] <= in_dat_i;
        end
    end
endmodule

// File: tb/tb_conv_col_gen.sv
// tb_conv_col_gen: directed check of conv_col_gen on a 4x3 image
module tb_conv_col_gen;
    localparam int PW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          in_vld_i = 1'b0;
    logic          in_sof_i = 1'b0;
    logic [PW-1:0] in_dat_i = '0;
    logic          in_rdy_o;
    logic          col_push_o;
    logic [2:0]    col_vld_o;
    logic [2:0][PW-1:0] col_dat_o;
    logic [4:0]    col_pos_o;

    int total = 0;
    int bad = 0;

    conv_col_gen #(
        .KERNEL_DIAMETER_N(3),
        .PIXEL_W(PW),
        .IMAGE_W(W),
        .IMAGE_H(H),
        .KERNEL_POS_W(5)
    ) dut (
        .clk(clk),
        .arst(arst),
        .in_vld_i(in_vld_i),
        .in_rdy_o(in_rdy_o),
        .in_dat_i(in_dat_i),
        .in_sof_i(in_sof_i),
        .col_push_o(col_push_o),
        .col_vld_o(col_vld_o),
        .col_dat_o(col_dat_o),
        .col_pos_o(col_pos_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [7:0] d, input logic s);
        in_vld_i = 1'b1;
        in_dat_i = d;
        in_sof_i = s;
        step();
        in_vld_i = 1'b0;
        in_sof_i = 1'b0;
    endtask

    task automatic col(input string tag, input logic [2:0] v, input logic [7:0] d2,
                       input logic [7:0] d1, input logic [7:0] d0, input logic [4:0] p);
        chk({tag, ".push"}, 32'(col_push_o), 32'd1);
        chk({tag, ".vld"}, 32'(col_vld_o), 32'(v));
        chk({tag, ".dat"}, 32'(col_dat_o), 32'({d2, d1, d0}));
        chk({tag, ".pos"}, 32'(col_pos_o), 32'(p));
    endtask

    task automatic idle_zero(input string tag);
        chk({tag, ".push"}, 32'(col_push_o), 32'd0);
        chk({tag, ".vld"}, 32'(col_vld_o), 32'd0);
        chk({tag, ".dat"}, 32'(col_dat_o), 32'd0);
        chk({tag, ".pos"}, 32'(col_pos_o), 32'd0);
        chk({tag, ".rdy"}, 32'(in_rdy_o), 32'd1);
    endtask

    initial begin
        repeat (2) step();
        idle_zero("rst0");
        arst = 1'b0;
        step();
        idle_zero("idle");

        // row 0 of a first frame: 1..4
        px(8'd1, 1'b0); col("r0c0", 3'b100, 8'd1, 8'd0, 8'd0, 5'b00101);
        px(8'd2, 1'b0); col("r0c1", 3'b100, 8'd2, 8'd0, 8'd0, 5'b00100);
        px(8'd3, 1'b0); col("r0c2", 3'b100, 8'd3, 8'd0, 8'd0, 5'b00100);
        px(8'd4, 1'b0); col("r0c3", 3'b100, 8'd4, 8'd0, 8'd0, 5'b00110);
        px(8'd10, 1'b0); col("r1c0", 3'b110, 8'd10, 8'd1, 8'd0, 5'b00001);
        px(8'd11, 1'b0); col("r1c1", 3'b110, 8'd11, 8'd2, 8'd0, 5'b00000);

        // asynchronous reset at (2,1)
        #2 arst = 1'b1;
        #1 idle_zero("arst");
        #2 arst = 1'b0;
        step();
        chk("postrst.push", 32'(col_push_o), 32'd0);

        // fresh frame, row 0: stale buffer data must stay masked
        px(8'd10, 1'b0); col("f0c0", 3'b100, 8'd10, 8'd0, 8'd0, 5'b00101);
        px(8'd11, 1'b0); col("f0c1", 3'b100, 8'd11, 8'd0, 8'd0, 5'b00100);
        px(8'd12, 1'b0); col("f0c2", 3'b100, 8'd12, 8'd0, 8'd0, 5'b00100);
        px(8'd13, 1'b0); col("f0c3", 3'b100, 8'd13, 8'd0, 8'd0, 5'b00110);

        // row 1 with a 3-cycle gap at x=2
        px(8'd20, 1'b0); col("f1c0", 3'b110, 8'd20, 8'd10, 8'd0, 5'b00001);
        px(8'd21, 1'b0); col("f1c1", 3'b110, 8'd21, 8'd11, 8'd0, 5'b00000);
        in_dat_i = 8'd77;
        in_sof_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap.push", 32'(col_push_o), 32'd0);
        end
        in_sof_i = 1'b0;
        px(8'd22, 1'b0); col("f1c2", 3'b110, 8'd22, 8'd12, 8'd0, 5'b00000);
        px(8'd23, 1'b0); col("f1c3", 3'b110, 8'd23, 8'd13, 8'd0, 5'b00010);

        // row 2, last row
        px(8'd30, 1'b0); col("f2c0", 3'b111, 8'd30, 8'd20, 8'd10, 5'b01001);
        px(8'd31, 1'b0); col("f2c1", 3'b111, 8'd31, 8'd21, 8'd11, 5'b01000);
        px(8'd32, 1'b0); col("f2c2", 3'b111, 8'd32, 8'd22, 8'd12, 5'b01000);
        px(8'd33, 1'b0); col("f2c3", 3'b111, 8'd33, 8'd23, 8'd13, 5'b01010);
        chk("fl.rdy0", 32'(in_rdy_o), 32'd0);

        // flush: inputs held active to prove they are ignored
        in_vld_i = 1'b1;
        in_dat_i = 8'd99;
        in_sof_i = 1'b1;
        step(); col("fl0", 3'b011, 8'd0, 8'd30, 8'd20, 5'b11001);
        chk("fl.rdy1", 32'(in_rdy_o), 32'd0);
        step(); col("fl1", 3'b011, 8'd0, 8'd31, 8'd21, 5'b11000);
        chk("fl.rdy2", 32'(in_rdy_o), 32'd0);
        step(); col("fl2", 3'b011, 8'd0, 8'd32, 8'd22, 5'b11000);
        chk("fl.rdy3", 32'(in_rdy_o), 32'd0);
        step(); col("fl3", 3'b011, 8'd0, 8'd33, 8'd23, 5'b11010);
        chk("fl.rdy4", 32'(in_rdy_o), 32'd1);
        in_vld_i = 1'b0;
        in_sof_i = 1'b0;
        step();
        chk("postfl.push", 32'(col_push_o), 32'd0);

        // next frame, then resync at (2,1)
        px(8'd40, 1'b0); col("g0c0", 3'b100, 8'd40, 8'd0, 8'd0, 5'b00101);
        px(8'd41, 1'b0); col("g0c1", 3'b100, 8'd41, 8'd0, 8'd0, 5'b00100);
        px(8'd42, 1'b0); col("g0c2", 3'b100, 8'd42, 8'd0, 8'd0, 5'b00100);
        px(8'd43, 1'b0); col("g0c3", 3'b100, 8'd43, 8'd0, 8'd0, 5'b00110);
        px(8'd50, 1'b0); col("g1c0", 3'b110, 8'd50, 8'd40, 8'd0, 5'b00001);
        px(8'd51, 1'b0); col("g1c1", 3'b110, 8'd51, 8'd41, 8'd0, 5'b00000);
        px(8'd7, 1'b1);  col("sof", 3'b100, 8'd7, 8'd0, 8'd0, 5'b00101);
        px(8'd8, 1'b0);  col("sof+1", 3'b100, 8'd8, 8'd0, 8'd0, 5'b00100);
        px(8'd9, 1'b0);  col("sof+2", 3'b100, 8'd9, 8'd0, 8'd0, 5'b00100);
        px(8'd6, 1'b0);  col("sof+3", 3'b100, 8'd6, 8'd0, 8'd0, 5'b00110);
        px(8'd60, 1'b0); col("sof.r1", 3'b110, 8'd60, 8'd7, 8'd0, 5'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_col_gen.md
# conv_col_gen

Raster-to-column generator for the convolution pipeline. It accepts a pixel stream in raster order over a valid/ready handshake and stores the previous image rows in internal line buffers. For each accepted pixel it emits one vertical column of `KERNEL_DIAMETER_N` pixels, with per-row validity and position flags, on the column push interface consumed by the kernel-window assembler. At end of frame it drives a bottom-padding flush row so that edge windows can complete.

## Interface
- `KERNEL_DIAMETER_N`, `conv_pkg::KERNEL_DIAMETER_N` (=3): column height; only 3 is supported (radius 1, one flush row).
- `PIXEL_W`, `conv_pkg::PIXEL_W`: pixel width.
- `IMAGE_W`, 8: pixels per row; minimum 2.
- `IMAGE_H`, 4: rows per frame; minimum 2.
- `KERNEL_POS_W`, 5: position flag width; bits are {flush, last_row, first_row, eol, sol}, with [0]=sol.
- `clk`  in  1  sole clock.
- `arst`  in  1  reset; asynchronous, active-high.
- `in_vld_i`  in  1  input pixel valid.
- `in_rdy_o`  out  1  block can accept a pixel.
- `in_dat_i`  in  PIXEL_W  input pixel.
- `in_sof_i`  in  1  this pixel is (0,0) of a new frame; qualified by accept.
- `col_push_o`  out  1  column valid this cycle; no backpressure.
- `col_vld_o`  out  KERNEL_DIAMETER_N  per-row real-data flag; 0 = padding.
- `col_dat_o`  out  `conv_pkg::pixel_span_t`  column pixels; index N-1 = newest row, index 0 = oldest row.
- `col_pos_o`  out  KERNEL_POS_W  position flags of the column.

## Operation
- Accept: `acc = in_vld_i & in_rdy_o`. `in_rdy_o = (state == STREAM)`.
- Counters: `x` ranges 0..IMAGE_W-1 and `y` ranges 0..IMAGE_H-1, each of width clog2 of its range.
  - On accept, `x` increments.
  - At `x == IMAGE_W-1`, `x` wraps to 0 and `y` increments.
  - No accept means `x` and `y` hold.
- Line buffers: `lb0` and `lb1`, each IMAGE_W pixels in a flop array.
  - On accept at column x, read `lb0[x]` and `lb1[x]` before writing.
  - Then write `lb0[x] <= lb1[x]` and `lb1[x] <= in_dat_i`.
- Column for an accepted pixel, registered:
  - `col_dat_o[2] = in_dat_i`, `[1] = lb1[x]`, `[0] = lb0[x]`.
  - `col_vld_o = {1, y>=1, y>=2}` for bits {[2], [1], [0]}.
  - Any row with vld=0 drives dat=0.
- Position flags: sol=(x==0), eol=(x==IMAGE_W-1), first_row=(y==0), last_row=(y==IMAGE_H-1), flush=0.
- Resync: an accepted pixel with `in_sof_i=1` is treated as (0,0) regardless of the counters.
  - Its column has vld 3'b100, sol=1, first_row=1.
  - Afterwards `x=1`, `y=0`.
  - Old line buffer contents are never marked valid, because vld is derived from `y`.
  - `in_sof_i` on a pixel already at (0,0) has no effect.
- State machine STREAM/FLUSH:
  - Reset state is STREAM.
  - STREAM→FLUSH on accept at x=IMAGE_W-1, y=IMAGE_H-1. `x` and `y` wrap to 0.
  - FLUSH emits one column per cycle for fx = 0..IMAGE_W-1:
    - `col_dat_o = {0, lb1[fx], lb0[fx]}`, `col_vld_o = 3'b011`.
    - Flags: flush=1, last_row=1, sol/eol per fx, first_row=0.
    - Line buffers are not written.
  - FLUSH→STREAM after the fx=IMAGE_W-1 column.
- Reset (`arst`) at any time, including mid-frame or mid-flush:
  - state=STREAM, x=y=fx=0.
  - All outputs are 0 except `in_rdy_o`, which reads 1.
  - Line buffer contents are don't-care.

## Timing
- Latency: `col_push_o` and the column data appear exactly 1 cycle after the accepting edge. There is one push per accept and no push on idle cycles.
- Flush timing:
  - `in_rdy_o` drops in the cycle after the last-pixel accept.
  - It stays low for exactly IMAGE_W cycles.
  - Flush columns appear on consecutive cycles, starting 1 cycle after the last data column.
- Stream resumes: `in_rdy_o=1` in the cycle after the final flush column is registered. Total stall per frame is IMAGE_W cycles.
- Output rate: at most 1 column per cycle. `col_push_o` is never asserted in two overlapping roles.
- `in_sof_i` and `in_dat_i` are ignored when not accepted, including during FLUSH.

## Test plan
- **Reset:** assert `arst` mid-row (x=2, y=1), then release.
  - Required: `col_push_o`, `col_vld_o`, `col_dat_o`, `col_pos_o` are 0; `in_rdy_o`=1.
  - Required: the next accepted pixel yields vld 3'b100 with sol and first_row set.
- **Row 0** (IMAGE_W=4, IMAGE_H=3): pixels 1,2,3,4 back-to-back.
  - Required: 4 pushes, each 1 cycle late, `col_dat_o={p,0,0}`, vld 3'b100.
  - Required: pos 5'b00101 on the first column, 5'b00110 on the last.
- **Row 2:** rows 10..13 and 20..23 were sent first; then send 30.
  - Required: column {30,20,10}, vld 3'b111, pos 5'b01001.
- **Flush:** accept the last pixel 33 at (3,2).
  - Required: `in_rdy_o` is low for 4 cycles.
  - Required: columns {0,30,20} .. {0,33,23}, vld 3'b011, flush=1.
  - Required: `in_rdy_o` returns high after, and the next pixel is first_row.
- **Gaps:** drop `in_vld_i` for 3 cycles at x=2.
  - Required: no push in those cycles, `x` holds, and the next column has x=2 flags and the correct `lb` data.
- **Resync:** assert `in_sof_i` at (2,1) with pixel 7.
  - Required: column {7,0,0}, vld 3'b100, sol=1, first_row=1.
  - Required: the following pixel has x=1, y=0.
